// File: rtl/mem_scan_ctrl.sv
// mem_scan_ctrl: paced read sequencer for data_mem feeding a held display register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   btn_pause, btn_fast : raw buttons (pause toggles on rising edge, fast is a level)
//   rd_en, data_addr    : read request to data_mem (1-cycle registered read)
//   mem_data            : data_mem read data
//   disp_data           : last captured word, held stable
//   disp_valid          : one-cycle strobe when disp_data updates
//   paused              : high while scanning is paused
module mem_scan_ctrl #(
  parameter int ADDR_NUM   = 128,
  parameter int ADDR_WIDTH = $clog2(ADDR_NUM),
  parameter int DATA_WIDTH = 32,
  parameter int TICK_DIV   = 50_000_000,
  parameter int FAST_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_pause,
  input  logic                  btn_fast,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  disp_valid,
  output logic                  paused
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int FP = (TICK_DIV >> FAST_SHIFT) < 1 ? 1 : (TICK_DIV >> FAST_SHIFT);
  localparam logic [CW-1:0] LIM_N = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LIM_F = CW'(FP - 1);
  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(ADDR_NUM - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WAIT_TICK, PAUSED} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_disp;
  logic                  r_valid;
  logic [CW-1:0]         r_cnt, w_cnt_nx, w_lim;
  logic                  r_tgl, w_tgl_nx, w_ev, w_cap;
  logic [2:0]            r_ps;
  logic [1:0]            r_fs;
  assign w_ev       = r_ps[1] & ~r_ps[2];
  assign w_lim      = r_fs[1] ? LIM_F : LIM_N;
  assign rd_en      = r_state == ISSUE;
  assign paused     = r_state == PAUSED;
  assign data_addr  = r_addr;
  assign disp_data  = r_disp;
  assign disp_valid = r_valid;
  // A pause event arms the toggle everywhere except PAUSED, where it releases it.
  assign w_tgl_nx = w_ev ? (r_state != PAUSED) : r_tgl;
  always_comb begin
    w_next   = r_state;
    w_cnt_nx = r_cnt;
    w_cap    = 1'b0;
    case (r_state)
      IDLE:    w_next = ISSUE;
      ISSUE:   w_next = CAPTURE;
      CAPTURE: begin
        w_cap    = 1'b1;
        w_cnt_nx = '0;
        w_next   = (r_tgl | w_ev) ? PAUSED : WAIT_TICK;
      end
      WAIT_TICK: begin
        // >= so that switching to the shorter period never overruns the count.
        w_next   = w_ev ? PAUSED : (r_cnt >= w_lim) ? ISSUE : WAIT_TICK;
        w_cnt_nx = w_ev ? r_cnt : (r_cnt >= w_lim) ? '0 : r_cnt + 1'b1;
      end
      PAUSED:  w_next = w_ev ? WAIT_TICK : PAUSED;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_disp  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_tgl   <= 1'b0;
      r_ps    <= '0;
      r_fs    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nx;
      r_tgl   <= w_tgl_nx;
      r_ps    <= {r_ps[1:0], btn_pause};
      r_fs    <= {r_fs[0], btn_fast};
      r_valid <= w_cap;
      if (w_cap) begin
        r_disp <= mem_data;
        r_addr <= (r_addr == A_LAST) ? '0 : r_addr + 1'b1;
      end
    end
  end
endmodule
